// File: rtl/ula_pkg.sv
// Shared definitions for the ALU sequencer: data width, ALU opcodes and FSM states.
package ula_pkg;

   localparam int DATA_W = 4;

   // Opcode order follows the ALU result mux, {z,y,x}
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_SHL = 3'd2;
   localparam logic [2:0] OP_SHR = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_XOR = 3'd6;
   localparam logic [2:0] OP_NOT = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } seq_state_t;

endpackage

// File: rtl/ula_seq_if.sv
// Command/response bus of the ALU sequencer. Flag outputs exist only when
// ULA_SEQ_FLAGS_EN is defined.
interface ula_seq_if;
   import ula_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [DATA_W-1:0] cmd_data;
   logic              cmd_load;
   logic [1:0]        cmd_rep;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic              res_zero;
`ifdef ULA_SEQ_FLAGS_EN
   logic              res_carry;
   logic              res_ovf;

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_load, cmd_rep, res_ready,
      output cmd_ready, res_valid, res_data, res_zero, res_carry, res_ovf
   );
   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_load, cmd_rep, res_ready,
      input  cmd_ready, res_valid, res_data, res_zero, res_carry, res_ovf
   );
`else
   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_load, cmd_rep, res_ready,
      output cmd_ready, res_valid, res_data, res_zero
   );
   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_load, cmd_rep, res_ready,
      input  cmd_ready, res_valid, res_data, res_zero
   );
`endif

endinterface

// File: rtl/ula_seq.sv
// Accumulator sequencer driving an external combinational 4-bit ALU.
// Define ULA_SEQ_FLAGS_EN to add registered carry/overflow flags for ADD/SUB.
module ula_seq
   import ula_pkg::*;
#(
   parameter logic [DATA_W-1:0] ACC_RST = 4'h0
) (
   input  logic              clk,
   input  logic              rst,
   ula_seq_if.slave          bus,
   output logic [DATA_W-1:0] ula_a,
   output logic [DATA_W-1:0] ula_b,
   output logic              ula_x,
   output logic              ula_y,
   output logic              ula_z,
   input  logic [DATA_W-1:0] ula_s
);

   seq_state_t        state, state_nxt;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] data_q;
   logic [2:0]        op_q;
   logic [1:0]        cnt;
   logic              accept;

   assign accept = bus.cmd_valid & bus.cmd_ready;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: the default comes first so no path leaves state_nxt unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (accept) state_nxt = bus.cmd_load ? ST_RESP : ST_EXEC;
         ST_EXEC: if (cnt == 2'd0) state_nxt = ST_RESP;
         ST_RESP: if (bus.res_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The remaining repeat count doubles as the latched cmd_rep field
   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= ACC_RST;
         cnt    <= 2'd0;
         op_q   <= 3'd0;
         data_q <= '0;
      end else begin
         if (accept) begin
            op_q   <= bus.cmd_op;
            data_q <= bus.cmd_data;
            if (bus.cmd_load) acc <= bus.cmd_data;
            else              cnt <= bus.cmd_rep;
         end
         if (state == ST_EXEC) begin
            acc <= ula_s;
            if (cnt != 2'd0) cnt <= cnt - 2'd1;
         end
      end
   end

   always_comb begin
      ula_b = '0;
      {ula_z, ula_y, ula_x} = 3'b000;
      if (state == ST_EXEC) begin
         ula_b = data_q;
         {ula_z, ula_y, ula_x} = op_q;
      end
   end

   assign ula_a         = acc;
   assign bus.cmd_ready = (state == ST_IDLE);
   assign bus.res_valid = (state == ST_RESP);
   assign bus.res_data  = acc;
   assign bus.res_zero  = (acc == '0);

`ifdef ULA_SEQ_FLAGS_EN
   logic [DATA_W:0] sum_ext, diff_ext;
   logic            carry_nxt, ovf_nxt;
   logic            carry_q, ovf_q;

   // Shadow 5-bit add/sub, evaluated against the same operands the ALU sees
   always_comb begin
      sum_ext   = {1'b0, acc} + {1'b0, data_q};
      diff_ext  = {1'b0, acc} - {1'b0, data_q};
      carry_nxt = 1'b0;
      ovf_nxt   = 1'b0;
      if (op_q == OP_ADD) begin
         carry_nxt = sum_ext[DATA_W];
         ovf_nxt   = (acc[DATA_W-1] == data_q[DATA_W-1]) &&
                     (sum_ext[DATA_W-1] != acc[DATA_W-1]);
      end else if (op_q == OP_SUB) begin
         carry_nxt = diff_ext[DATA_W];
         ovf_nxt   = (acc[DATA_W-1] != data_q[DATA_W-1]) &&
                     (diff_ext[DATA_W-1] != acc[DATA_W-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept && bus.cmd_load) begin
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (state == ST_EXEC) begin
         carry_q <= carry_nxt;
         ovf_q   <= ovf_nxt;
      end
   end

   assign bus.res_carry = carry_q;
   assign bus.res_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq with a behavioural ALU beside it and a
// transaction-level accumulator model. Flag checks follow ULA_SEQ_FLAGS_EN.
module tb_ula_seq;
   import ula_pkg::*;

   localparam logic [3:0] ACC_RST = 4'h6;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] ula_a, ula_b, ula_s;
   logic       ula_x, ula_y, ula_z;

   ula_seq_if io ();

   ula_seq #(.ACC_RST(ACC_RST)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (io.slave),
      .ula_a (ula_a),
      .ula_b (ula_b),
      .ula_x (ula_x),
      .ula_y (ula_y),
      .ula_z (ula_z),
      .ula_s (ula_s)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [3:0] m_acc;

   function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return {a[2:0], 1'b0};
         3'd3:    return {1'b0, a[3:1]};
         3'd4:    return a & b;
         3'd5:    return a | b;
         3'd6:    return a ^ b;
         default: return ~a;
      endcase
   endfunction

`ifdef ULA_SEQ_FLAGS_EN
   // Returns {carry_or_borrow, signed_overflow} from integer arithmetic
   function automatic logic [1:0] flags_ref(input logic [2:0] op, input logic [3:0] a,
                                            input logic [3:0] b);
      int ua, ub, sa, sb, sr;
      ua = int'(a); ub = int'(b);
      sa = int'($signed(a)); sb = int'($signed(b));
      if (op == 3'd0) begin
         sr = sa + sb;
         return {ua + ub > 15, (sr > 7) || (sr < -8)};
      end else if (op == 3'd1) begin
         sr = sa - sb;
         return {ua < ub, (sr > 7) || (sr < -8)};
      end
      return 2'b00;
   endfunction
`endif

   // Combinational ALU model sitting next to the sequencer
   always_comb ula_s = alu_ref({ula_z, ula_y, ula_x}, ula_a, ula_b);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge with the sequencer idle; returns at a falling edge, idle again
   task automatic send_cmd(input logic [2:0] op, input logic [3:0] b, input bit ld,
                           input logic [1:0] rep, input int hold);
      logic [3:0] resp;
`ifdef ULA_SEQ_FLAGS_EN
      logic [1:0] exp_fl = 2'b00;
`endif
      check("idle_cmd_ready", io.cmd_ready, 1);
      io.cmd_valid = 1; io.cmd_op = op; io.cmd_data = b;
      io.cmd_load = ld; io.cmd_rep = rep;
      @(negedge clk);
      io.cmd_valid = 0;
      if (ld) m_acc = b;
      else begin
         for (int i = 0; i <= int'(rep); i++) begin
            check("exec_cmd_ready", io.cmd_ready, 0);
            check("exec_res_valid", io.res_valid, 0);
            check("exec_sel", {ula_z, ula_y, ula_x}, op);
            check("exec_ula_b", ula_b, b);
            check("exec_ula_a", ula_a, m_acc);
`ifdef ULA_SEQ_FLAGS_EN
            exp_fl = flags_ref(op, m_acc, b);
`endif
            m_acc = alu_ref(op, m_acc, b);
            @(negedge clk);
         end
      end
      resp = m_acc;
      check("resp_valid", io.res_valid, 1);
      check("resp_data", io.res_data, resp);
      check("resp_zero", io.res_zero, resp == 4'h0);
      check("resp_idle_lines", {ula_b, ula_z, ula_y, ula_x}, 7'h00);
`ifdef ULA_SEQ_FLAGS_EN
      check("resp_flags", {io.res_carry, io.res_ovf}, exp_fl);
`endif
      for (int i = 0; i < hold; i++) begin
         io.cmd_valid = 1; io.cmd_load = 1; io.cmd_data = ~resp;
         @(negedge clk);
         check("hold_valid", io.res_valid, 1);
         check("hold_data", io.res_data, resp);
         check("hold_cmd_ready", io.cmd_ready, 0);
      end
      io.cmd_valid = 0; io.cmd_load = 0;
      io.res_ready = 1;
      @(negedge clk);
      io.res_ready = 0;
      check("post_hs_cmd_ready", io.cmd_ready, 1);
      check("post_hs_res_valid", io.res_valid, 0);
      check("post_hs_acc", io.res_data, m_acc);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

   initial begin
      int         cyc, last_cyc;
      bit         have_prev, prev_ld, ld;
      logic [2:0] op;
      logic [3:0] b;

      rst = 1;
      io.cmd_valid = 0; io.cmd_op = 0; io.cmd_data = 0;
      io.cmd_load = 0; io.cmd_rep = 0; io.res_ready = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      m_acc = ACC_RST;
      check("rst_cmd_ready", io.cmd_ready, 1);
      check("rst_res_valid", io.res_valid, 0);
      check("rst_res_data", io.res_data, ACC_RST);
      check("rst_res_zero", io.res_zero, ACC_RST == 4'h0);
      check("rst_ula_a", ula_a, ACC_RST);
      check("rst_ula_b_sel", {ula_b, ula_z, ula_y, ula_x}, 7'h00);
`ifdef ULA_SEQ_FLAGS_EN
      check("rst_flags", {io.res_carry, io.res_ovf}, 2'b00);
`endif

      // Directed cases
      send_cmd(OP_ADD, 4'h0, 1'b1, 2'd0, 0);
      send_cmd(OP_ADD, 4'h9, 1'b1, 2'd0, 0);
      send_cmd(OP_ADD, 4'h8, 1'b0, 2'd0, 0);
      send_cmd(OP_ADD, 4'h1, 1'b1, 2'd0, 0);
      send_cmd(OP_SHL, 4'h1, 1'b0, 2'd3, 5);
      send_cmd(OP_ADD, 4'h5, 1'b1, 2'd0, 0);
      send_cmd(OP_NOT, 4'h0, 1'b0, 2'd0, 1);
      send_cmd(OP_ADD, 4'h7, 1'b1, 2'd0, 0);

      // Reset in the second EXEC cycle of a rep=3 SUB
      io.cmd_valid = 1; io.cmd_op = OP_SUB; io.cmd_data = 4'h1;
      io.cmd_load = 0; io.cmd_rep = 2'd3;
      @(negedge clk);
      io.cmd_valid = 0;
      @(negedge clk);
      check("mid_exec_sel", {ula_z, ula_y, ula_x}, OP_SUB);
      rst = 1;
      @(negedge clk);
      rst = 0;
      m_acc = ACC_RST;
      check("mid_rst_cmd_ready", io.cmd_ready, 1);
      check("mid_rst_acc", ula_a, ACC_RST);
      check("mid_rst_sel", {ula_b, ula_z, ula_y, ula_x}, 7'h00);
      for (int i = 0; i < 6; i++) begin
         check("mid_rst_no_resp", io.res_valid, 0);
         @(negedge clk);
      end

      // Back-to-back stream, res_ready tied high: ALU ops every 3 cycles, loads every 2
      io.res_ready = 1; io.cmd_valid = 1; io.cmd_rep = 0;
      have_prev = 0; prev_ld = 0; last_cyc = 0; cyc = 0;
      repeat (60) begin
         if (io.res_valid) check("tp_res_data", io.res_data, m_acc);
         if (io.cmd_ready) begin
            if (have_prev) check("tp_gap", cyc - last_cyc, prev_ld ? 2 : 3);
            ld = ($urandom_range(0, 3) == 0);
            op = 3'($urandom_range(0, 7));
            b  = 4'($urandom_range(0, 15));
            io.cmd_op = op; io.cmd_data = b; io.cmd_load = ld;
            m_acc = ld ? b : alu_ref(op, m_acc, b);
            last_cyc = cyc; prev_ld = ld; have_prev = 1;
         end
         @(negedge clk);
         cyc++;
      end
      io.cmd_valid = 0; io.cmd_load = 0;
      for (int i = 0; i < 4 && !io.cmd_ready; i++) begin
         if (io.res_valid) check("tp_drain_data", io.res_data, m_acc);
         @(negedge clk);
      end
      check("tp_drain_idle", io.cmd_ready, 1);
      io.res_ready = 0;

      // Randomized commands with random repeat counts and consumer stalls
      for (int n = 0; n < 25; n++) begin
         send_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
